// File: rtl/arcade_ctrl_merge.sv
// Joystick merge with per-bit debounce, coin queue and coin pulse shaper.
// Optional autofire on one button is built in when ARCADE_CTRL_AUTOFIRE_EN is defined.
module arcade_ctrl_merge #(
  parameter int NPLAYERS  = 2,
  parameter int NBTN      = 16,
  parameter int DEB_TICKS = 4,
  parameter int COIN_BIT  = 8,
  parameter int COIN_ON   = 6,
  parameter int COIN_OFF  = 6
`ifdef ARCADE_CTRL_AUTOFIRE_EN
  ,
  parameter int AF_BIT    = 4,
  parameter int AF_HALF   = 3
`endif
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     ce_tick,
  input  logic [NPLAYERS*NBTN-1:0] joy_in,
  input  logic                     cocktail,
  input  logic [1:0]               active_player,
`ifdef ARCADE_CTRL_AUTOFIRE_EN
  input  logic                     autofire,
`endif
  output logic [NBTN-1:0]          btn_out,
  output logic                     coin_pulse,
  output logic [1:0]               coin_pending
);

  localparam logic [7:0]      DEB_LAST  = 8'(DEB_TICKS - 1);
  localparam logic [7:0]      ON_LAST   = 8'(COIN_ON - 1);
  localparam logic [7:0]      OFF_LAST  = 8'(COIN_OFF - 1);
  localparam logic [NBTN-1:0] COIN_MASK = {{(NBTN-1){1'b0}}, 1'b1} << COIN_BIT;
`ifdef ARCADE_CTRL_AUTOFIRE_EN
  localparam logic [7:0]      AF_LAST   = 8'(AF_HALF - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } coin_st_e;

  logic [1:0]      rst_sync_q;
  logic            rst_n_s;
  logic [NBTN-1:0] src_s;
  logic [NBTN-1:0] raw_s;
  logic            coin_src_s;
  logic [7:0]      cnt_q [NBTN];
  logic [7:0]      cnt_d [NBTN];
  logic [NBTN-1:0] deb_q, deb_d;
  logic [NBTN-1:0] btn_q, btn_d;
  logic            coin_prev_q;
  logic            coin_rise_s;
  logic            inc_s, dec_s;
  logic [1:0]      pend_q, pend_d;
  coin_st_e        state_q, state_d;
  logic [7:0]      tmr_q, tmr_d;
  logic            pulse_q, pulse_d;
`ifdef ARCADE_CTRL_AUTOFIRE_EN
  logic [7:0]      af_cnt_q, af_cnt_d;
  logic            af_phase_q, af_phase_d;
`endif

  // Reset asserts asynchronously, releases two clk_sys edges later
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_q[1];

  // Source selection; the coin bit is always merged from every player
  always_comb begin
    src_s      = '0;
    coin_src_s = 1'b0;
    for (int p = 0; p < NPLAYERS; p++) begin
      coin_src_s = coin_src_s | joy_in[p*NBTN + COIN_BIT];
      if (cocktail) begin
        src_s = src_s | (joy_in[p*NBTN +: NBTN] & {NBTN{active_player == 2'(p)}});
      end else begin
        src_s = src_s | joy_in[p*NBTN +: NBTN];
      end
    end
    raw_s           = src_s;
    raw_s[COIN_BIT] = coin_src_s;
  end

  // Per-bit debounce: a bit flips only after DEB_TICKS consecutive differing ticks
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (ce_tick) begin
      for (int i = 0; i < NBTN; i++) begin
        if (raw_s[i] == deb_q[i]) begin
          cnt_d[i] = 8'd0;
        end else if (cnt_q[i] == DEB_LAST) begin
          cnt_d[i] = 8'd0;
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end else begin
      deb_d = deb_q;
    end
  end

`ifdef ARCADE_CTRL_AUTOFIRE_EN
  // Autofire phase runs only while the debounced fire bit is held
  always_comb begin
    af_cnt_d   = af_cnt_q;
    af_phase_d = af_phase_q;
    if (autofire && deb_q[AF_BIT]) begin
      if (ce_tick) begin
        if (af_cnt_q == AF_LAST) begin
          af_cnt_d   = 8'd0;
          af_phase_d = ~af_phase_q;
        end else begin
          af_cnt_d = af_cnt_q + 8'd1;
        end
      end else begin
        af_cnt_d = af_cnt_q;
      end
    end else begin
      af_cnt_d   = 8'd0;
      af_phase_d = 1'b0;
    end
    btn_d         = deb_q & ~COIN_MASK;
    btn_d[AF_BIT] = deb_q[AF_BIT] & ~(autofire & af_phase_q);
  end

  // Autofire state
  always_ff @(posedge clk_sys or negedge rst_n_s) begin
    if (!rst_n_s) begin
      af_cnt_q   <= 8'd0;
      af_phase_q <= 1'b0;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end
`else
  // Output word is the debounced word with the coin position cleared
  always_comb begin
    btn_d = deb_q & ~COIN_MASK;
  end
`endif

  assign coin_rise_s = deb_q[COIN_BIT] & ~coin_prev_q;

  // Coin pulse FSM and saturating coin queue
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    dec_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q != 2'd0) begin
          state_d = ST_ON;
          tmr_d   = 8'd0;
          dec_s   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ON: begin
        if (ce_tick) begin
          if (tmr_q == ON_LAST) begin
            state_d = ST_OFF;
            tmr_d   = 8'd0;
          end else begin
            tmr_d = tmr_q + 8'd1;
          end
        end else begin
          tmr_d = tmr_q;
        end
      end
      ST_OFF: begin
        if (ce_tick) begin
          if (tmr_q == OFF_LAST) begin
            state_d = ST_IDLE;
            tmr_d   = 8'd0;
          end else begin
            tmr_d = tmr_q + 8'd1;
          end
        end else begin
          tmr_d = tmr_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = 8'd0;
      end
    endcase

    inc_s = coin_rise_s & (pend_q != 2'd3);
    case ({inc_s, dec_s})
      2'b10:   pend_d = pend_q + 2'd1;
      2'b01:   pend_d = pend_q - 2'd1;
      default: pend_d = pend_q;
    endcase

    pulse_d = (state_d == ST_ON);
  end

  // Main state registers
  always_ff @(posedge clk_sys or negedge rst_n_s) begin
    if (!rst_n_s) begin
      for (int i = 0; i < NBTN; i++) begin
        cnt_q[i] <= 8'd0;
      end
      deb_q       <= '0;
      btn_q       <= '0;
      coin_prev_q <= 1'b0;
      pend_q      <= 2'd0;
      state_q     <= ST_IDLE;
      tmr_q       <= 8'd0;
      pulse_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      deb_q       <= deb_d;
      btn_q       <= btn_d;
      coin_prev_q <= deb_q[COIN_BIT];
      pend_q      <= pend_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      pulse_q     <= pulse_d;
    end
  end

  assign btn_out      = btn_q;
  assign coin_pulse   = pulse_q;
  assign coin_pending = pend_q;

endmodule

// File: tb/tb_arcade_ctrl_merge.sv
// Directed bench: u_dut uses default parameters; u_fast (DEB_TICKS=1) lets coin presses
// arrive faster than pulses drain so the queue can saturate.
module tb_arcade_ctrl_merge;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ce_tick;
  logic        cocktail;
  logic [1:0]  active_player;
  logic [31:0] joy_in;
  logic [31:0] joy_in_f;
  logic [15:0] btn_out, btn_out_f;
  logic        coin_pulse, coin_pulse_f;
  logic [1:0]  coin_pending, coin_pending_f;

  int vecs = 0;
  int errs = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_ctrl_merge u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_tick(ce_tick), .joy_in(joy_in),
    .cocktail(cocktail), .active_player(active_player),
    .btn_out(btn_out), .coin_pulse(coin_pulse), .coin_pending(coin_pending)
  );

  arcade_ctrl_merge #(.DEB_TICKS(1)) u_fast (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_tick(ce_tick), .joy_in(joy_in_f),
    .cocktail(cocktail), .active_player(active_player),
    .btn_out(btn_out_f), .coin_pulse(coin_pulse_f), .coin_pending(coin_pending_f)
  );

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic tick();
    ce_tick = 1'b1;
    step();
    ce_tick = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ce_tick = 1'b0; cocktail = 1'b0; active_player = 2'd0;
    joy_in = 32'h0; joy_in_f = 32'h0;
    repeat (3) step();
    vecs++; if (btn_out !== 16'h0000) begin errs++; $display("FAIL reset_btn: got %h want 0000", btn_out); end
    vecs++; if (coin_pulse !== 1'b0) begin errs++; $display("FAIL reset_pulse: got %b want 0", coin_pulse); end
    vecs++; if (coin_pending !== 2'd0) begin errs++; $display("FAIL reset_pending: got %0d want 0", coin_pending); end
    vecs++; if (btn_out_f !== 16'h0000) begin errs++; $display("FAIL reset_btn_fast: got %h want 0000", btn_out_f); end
    reset_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_latency();
    joy_in = 32'h0001_0000;
    ticks(3);
    vecs++; if (btn_out !== 16'h0000) begin errs++; $display("FAIL lat_3ticks: got %h want 0000", btn_out); end
    ce_tick = 1'b1; step(); ce_tick = 1'b0;
    vecs++; if (btn_out !== 16'h0000) begin errs++; $display("FAIL lat_tick4_edge: got %h want 0000", btn_out); end
    step();
    vecs++; if (btn_out !== 16'h0001) begin errs++; $display("FAIL lat_tick4_plus1: got %h want 0001", btn_out); end
    joy_in = 32'h0;
    ticks(4);
    vecs++; if (btn_out !== 16'h0000) begin errs++; $display("FAIL lat_release: got %h want 0000", btn_out); end
  endtask

  task automatic test_cocktail_select();
    cocktail = 1'b1; active_player = 2'd1; joy_in = 32'h0000_0020;
    ticks(5);
    vecs++; if (btn_out !== 16'h0000) begin errs++; $display("FAIL ck_other_player: got %h want 0000", btn_out); end
    active_player = 2'd0;
    ticks(3);
    vecs++; if (btn_out !== 16'h0000) begin errs++; $display("FAIL ck_sel_3ticks: got %h want 0000", btn_out); end
    ticks(1);
    vecs++; if (btn_out !== 16'h0020) begin errs++; $display("FAIL ck_sel_4ticks: got %h want 0020", btn_out); end
    active_player = 2'd3;
    ticks(4);
    vecs++; if (btn_out !== 16'h0000) begin errs++; $display("FAIL ck_absent_player: got %h want 0000", btn_out); end
    cocktail = 1'b0; active_player = 2'd0; joy_in = 32'h0;
    ticks(2);
  endtask

  task automatic test_glitch();
    joy_in = 32'h0000_0002;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vecs++; if (btn_out !== 16'h0000) begin errs++; $display("FAIL glitch_tick%0d: got %h want 0000", k, btn_out); end
    end
    joy_in = 32'h0;
    ticks(3);
    vecs++; if (btn_out !== 16'h0000) begin errs++; $display("FAIL glitch_after: got %h want 0000", btn_out); end
    joy_in = 32'h0000_0002;
    ticks(4);
    vecs++; if (btn_out !== 16'h0002) begin errs++; $display("FAIL pulse4_passes: got %h want 0002", btn_out); end
    joy_in = 32'h0;
    ticks(4);
    vecs++; if (btn_out !== 16'h0000) begin errs++; $display("FAIL pulse4_release: got %h want 0000", btn_out); end
  endtask

  task automatic test_merge_and_coin_mask();
    joy_in = 32'h0008_0104;
    ticks(4);
    vecs++; if (btn_out !== 16'h000C) begin errs++; $display("FAIL merge_or: got %h want 000c", btn_out); end
    vecs++; if (coin_pending !== 2'd1) begin errs++; $display("FAIL coin_queued: got %0d want 1", coin_pending); end
    vecs++; if (coin_pulse !== 1'b0) begin errs++; $display("FAIL coin_not_yet: got %b want 0", coin_pulse); end
    step();
    vecs++; if (coin_pulse !== 1'b1) begin errs++; $display("FAIL coin_start: got %b want 1", coin_pulse); end
    vecs++; if (coin_pending !== 2'd0) begin errs++; $display("FAIL coin_dequeued: got %0d want 0", coin_pending); end
    joy_in = 32'h0;
    ticks(4);
    vecs++; if (btn_out !== 16'h0000) begin errs++; $display("FAIL merge_release: got %h want 0000", btn_out); end
  endtask

  task automatic test_switch_keeps_count();
    cocktail = 1'b1; active_player = 2'd0; joy_in = 32'h0080_0080;
    ticks(2);
    active_player = 2'd1;
    ticks(1);
    vecs++; if (btn_out !== 16'h0000) begin errs++; $display("FAIL switch_3ticks: got %h want 0000", btn_out); end
    ticks(1);
    vecs++; if (btn_out !== 16'h0080) begin errs++; $display("FAIL switch_4ticks: got %h want 0080", btn_out); end
    cocktail = 1'b0; active_player = 2'd0; joy_in = 32'h0;
    ticks(4);
    vecs++; if (btn_out !== 16'h0000) begin errs++; $display("FAIL switch_release: got %h want 0000", btn_out); end
  endtask

  task automatic test_coin_queue();
    int npulse = 0;
    int hi = 0;
    int lo = 0;
    int peak = 0;
    logic prev = 1'b0;
    logic mask_bad = 1'b0;
    for (int c = 0; c < 240; c++) begin
      ce_tick  = (c % 2 == 0);
      joy_in_f = ((c / 2) < 10 && ((c / 2) % 2 == 0)) ? 32'h0000_0100 : 32'h0;
      if (int'(coin_pending_f) > peak) peak = int'(coin_pending_f);
      if (btn_out_f[8] !== 1'b0) mask_bad = 1'b1;
      if (coin_pulse_f && !prev) begin
        if (npulse > 0) begin
          vecs++; if (lo < 6) begin errs++; $display("FAIL coin_gap%0d: got %0d low ticks want >=6", npulse, lo); end
        end
        npulse++;
        hi = 0;
      end else if (!coin_pulse_f && prev) begin
        vecs++; if (hi != 6) begin errs++; $display("FAIL coin_width%0d: got %0d high ticks want 6", npulse, hi); end
        lo = 0;
      end
      if (ce_tick) begin
        if (coin_pulse_f) hi++; else lo++;
      end
      prev = coin_pulse_f;
      step();
    end
    ce_tick = 1'b0;
    vecs++; if (npulse != 4) begin errs++; $display("FAIL coin_count: got %0d pulses want 4", npulse); end
    vecs++; if (peak != 3) begin errs++; $display("FAIL coin_peak: got %0d want 3", peak); end
    vecs++; if (coin_pending_f !== 2'd0) begin errs++; $display("FAIL coin_drained: got %0d want 0", coin_pending_f); end
    vecs++; if (mask_bad !== 1'b0) begin errs++; $display("FAIL coin_bit_masked: got %b want 0", mask_bad); end
  endtask

  task automatic test_reset_mid_pulse();
    logic found = 1'b0;
    logic seen = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      ce_tick  = (c % 2 == 0);
      joy_in_f = ((c / 2) < 4 && ((c / 2) % 2 == 0)) ? 32'h0000_0100 : 32'h0;
      step();
      if (coin_pulse_f === 1'b1 && coin_pending_f === 2'd1) found = 1'b1;
    end
    vecs++; if (found !== 1'b1) begin errs++; $display("FAIL rst_setup: got %b want 1 (pulse with one queued)", found); end
    ce_tick = 1'b0; joy_in_f = 32'h0;
    #2;
    reset_n = 1'b0;
    #1;
    vecs++; if (coin_pulse_f !== 1'b0) begin errs++; $display("FAIL rst_async_pulse: got %b want 0", coin_pulse_f); end
    vecs++; if (coin_pending_f !== 2'd0) begin errs++; $display("FAIL rst_async_pending: got %0d want 0", coin_pending_f); end
    step();
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 80; c++) begin
      ce_tick = (c % 2 == 0);
      step();
      if (coin_pulse_f !== 1'b0 || coin_pending_f !== 2'd0) seen = 1'b1;
    end
    ce_tick = 1'b0;
    vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL rst_no_pulse_after: got %b want 0", seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_latency();
    test_cocktail_select();
    test_glitch();
    test_merge_and_coin_mask();
    test_switch_keeps_count();
    test_coin_queue();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/arcade_ctrl_merge.md
ARCADE_CTRL_MERGE -- requirements
Module: arcade_ctrl_merge

Interface
REQ-001 Parameter NPLAYERS, default 2, number of joystick inputs merged, legal range 1..4.
REQ-002 Parameter NBTN, default 16, bits per joystick word.
REQ-003 Parameter DEB_TICKS, default 4, consecutive stable ce_tick samples required before a debounced bit changes, legal range 1..255.
REQ-004 Parameter COIN_BIT, default 8, index of the coin bit within each joystick word.
REQ-005 Parameter COIN_ON, default 6, ce_tick count the coin_pulse output is held high.
REQ-006 Parameter COIN_OFF, default 6, minimum ce_tick count coin_pulse is held low between pulses.
REQ-007 Port clk_sys, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 Port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-009 Port ce_tick, input, 1 bit: timer enable, single-cycle strobe in the clk_sys domain.
REQ-010 Port joy_in, input, NPLAYERS*NBTN bits: player p occupies bits [p*NBTN +: NBTN].
REQ-011 Port cocktail, input, 1 bit: 0 merges all players, 1 selects one player.
REQ-012 Port active_player, input, 2 bits: the player selected while cocktail=1.
REQ-013 Port btn_out, output, NBTN bits: debounced control word; its COIN_BIT position always reads 0.
REQ-014 Port coin_pulse, output, 1 bit: shaped coin pulse sent to the game core.
REQ-015 Port coin_pending, output, 2 bits: number of queued coins not yet pulsed.

Function
REQ-016 Source word: with cocktail=0, the OR of all joy_in players; with cocktail=1, the joy_in slice of active_player, or all-zero if active_player >= NPLAYERS.
REQ-017 The coin bit is taken as the OR of COIN_BIT across all players, independent of cocktail.
REQ-018 Each btn_out bit has its own counter, sampled only on ce_tick.
REQ-019 A counter resets to 0 on any tick where the source bit equals btn_out, and increments otherwise.
REQ-020 btn_out bit toggles on the tick the counter reaches DEB_TICKS; it then updates on the following clk_sys edge.
REQ-021 Minimum latency from a stable input change to btn_out is DEB_TICKS ticks plus 1 clk_sys cycle.
REQ-022 A glitch shorter than DEB_TICKS ticks never reaches btn_out.
REQ-023 The coin bit is debounced the same way, internally.
REQ-024 A debounced coin rising edge increments coin_pending, saturating at 3; an edge arriving at 3 is dropped.
REQ-025 The coin FSM has states IDLE, ON and OFF.
REQ-026 IDLE -> ON when coin_pending > 0; coin_pending decrements in the same cycle; coin_pulse=1 from that cycle.
REQ-027 ON -> OFF after COIN_ON ticks; coin_pulse=0.
REQ-028 OFF -> IDLE after COIN_OFF ticks.
REQ-029 If an increment and a decrement of coin_pending fall in the same cycle, the net count is unchanged.
REQ-030 cocktail or active_player changing mid-operation does not reset the debounce counters; the new source simply debounces in.
REQ-031 The coin FSM continues across a cocktail or active_player change.

Reset
REQ-032 While reset_n=0, btn_out=0, coin_pulse=0, coin_pending=0, all counters=0, FSM=IDLE, and the autofire phase=0.
REQ-033 Reset assertion takes effect immediately without a clock edge; deassertion is synchronised to clk_sys by two flops.
REQ-034 Reset asserted mid-pulse forces coin_pulse low at once and discards any queued coins.

Configuration
REQ-035 Macro ARCADE_CTRL_AUTOFIRE_EN, when defined, adds input autofire (1 bit) and parameter AF_BIT (default 4) and AF_HALF (default 3 ticks).
REQ-036 With the macro defined and autofire=1, while debounced bit AF_BIT is 1, btn_out[AF_BIT] toggles every AF_HALF ticks, starting at 1.
REQ-037 With the macro defined, btn_out[AF_BIT] drops to 0 within one clk_sys cycle of the debounced bit going low.
REQ-038 Without the macro, the autofire port and logic are absent and btn_out[AF_BIT] follows the debounced value only.

Verification
REQ-039 Scenario 1: NPLAYERS=2, cocktail=0, p1 bit0 held high -> btn_out[0]=1 exactly 4 ticks + 1 cycle later; p0 bits unaffected.
REQ-040 Scenario 2: cocktail=1, active_player=1, p0 bit5=1 -> btn_out[5] stays 0; switch to active_player=0 -> btn_out[5]=1 after 4 ticks.
REQ-041 Scenario 3: a 3-tick pulse on bit1 -> btn_out[1] stays 0 throughout.
REQ-042 Scenario 4: five clean coin presses in rapid succession -> coin_pending peaks at 3, exactly 4 pulses of 6 high ticks with >=6 low ticks between them.
REQ-043 Scenario 5: reset_n=0 during the ON state -> coin_pulse=0 with no clock edge, coin_pending=0, and no pulse after release.
REQ-044 Scenario 6 (macro defined): autofire=1, bit4 held -> btn_out[4] pattern 1,1,1,0,0,0 per tick, repeating; release -> 0 next cycle.
